// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared request types, bus FSM states and lane-fill helper
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2
    } msize_t;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        msize_t      size;
    } m_r_t;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        msize_t      size;
        logic [31:0] data;
    } m_w_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } dbus_state_t;

    localparam logic [31:0] PHYS_MASK_DEF = 32'h1FFF_FFFF;

    // Copy the low byte/half into every lane so the bus can use byte enables freely
    function automatic logic [31:0] lane_fill(input msize_t size, input logic [31:0] data);
        return size == MSIZE_B ? {4{data[7:0]}} :
               size == MSIZE_H ? {2{data[15:0]}} : data;
    endfunction

endpackage

// File: rtl/dmem_bridge_wdata_fmt.sv
// dmem_bridge_wdata_fmt: size-based store lane replication
module dmem_bridge_wdata_fmt
    import dmem_bridge_pkg::*;
#(
    parameter bit REPLICATE = 1'b1
) (
    input  msize_t      size,
    input  logic [31:0] data,
    output logic [31:0] wdata
);

    // Replicate narrow stores across lanes, or pass through when disabled
    always_comb wdata = REPLICATE ? lane_fill(size, data) : data;

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns MEM-stage load/store requests into single SRAM-like bus transactions
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter logic [31:0] PHYS_MASK = PHYS_MASK_DEF,
    parameter bit          REPLICATE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  m_r_t        mread,
    input  m_w_t        mwrite,
    output logic [31:0] rd,
    output logic        stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    dbus_state_t state;
    logic        new_req;
    msize_t      req_size;
    logic [31:0] req_addr;
    logic [31:0] fmt_wdata;

    dmem_bridge_wdata_fmt #(.REPLICATE(REPLICATE)) u_fmt (
        .size  (mwrite.size),
        .data  (mwrite.data),
        .wdata (fmt_wdata)
    );

    // Pick the winning request (store over load) and stall from the same cycle it appears
    always_comb begin
        new_req  = mread.en | mwrite.en;
        req_size = mwrite.en ? mwrite.size : mread.size;
        req_addr = mwrite.en ? mwrite.addr : mread.addr;
        stall    = (state == S_ADDR) | (state == S_DATA) | ((state == S_IDLE) & new_req);
    end

    // Bus FSM: latch request in IDLE, hold it stable until addr_ok, wait data_ok, release for one cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
            rd         <= 32'd0;
        end else begin
            case (state)
                S_IDLE: if (new_req) begin
                    state      <= S_ADDR;
                    data_req   <= 1'b1;
                    data_wr    <= mwrite.en;
                    data_size  <= req_size;
                    data_addr  <= req_addr & PHYS_MASK;
                    data_wdata <= fmt_wdata;
                end
                S_ADDR: if (data_addr_ok) begin
                    data_req <= 1'b0;
                    state    <= data_data_ok ? S_DONE : S_DATA;
                    if (data_data_ok && !data_wr) rd <= data_rdata;
                end
                S_DATA: if (data_data_ok) begin
                    state <= S_DONE;
                    if (!data_wr) rd <= data_rdata;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed plus randomized transactions against a cycle-schedule reference
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    m_r_t        mread;
    m_w_t        mwrite;
    logic [31:0] rd;
    logic        stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_hs  = 0;
    logic [31:0] exp_rd;

    dmem_bridge dut (
        .clk          (clk),
        .resetn       (resetn),
        .mread        (mread),
        .mwrite       (mwrite),
        .rd           (rd),
        .stall        (stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    // Count accepted bus requests to catch duplicated or missing transactions
    always @(posedge clk) if (resetn && data_req && data_addr_ok) n_hs++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic msize_t rsize();
        return msize_t'($urandom_range(0, 2));
    endfunction

    function automatic logic [31:0] model_wdata(input msize_t s, input logic [31:0] d);
        logic [31:0] r;
        if (s == MSIZE_B) r = d[7:0] * 32'h0101_0101;
        else if (s == MSIZE_H) r = d[15:0] * 32'h0001_0001;
        else r = d;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_req();
        mread  = '{en: 1'($urandom_range(0, 1)), addr: $urandom, size: rsize()};
        mwrite = '{en: 1'($urandom_range(0, 1)), addr: $urandom, size: rsize(), data: $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mread.en     = 1'b0;
            mwrite.en    = 1'b0;
            data_addr_ok = 1'($urandom_range(0, 1));
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata   = $urandom;
            @(negedge clk);
            chk("idle_stall", stall, 0);
            chk("idle_req", data_req, 0);
            chk("idle_rd", rd, exp_rd);
            step();
        end
    endtask

    // One transaction: addr_ok a cycles after data_req rises, data_ok d cycles after that
    task automatic do_txn(input logic re, input logic we, input logic [31:0] addr, input msize_t size,
                          input logic [31:0] data, input int a, input int d, input logic [31:0] rdata);
        int          hs0;
        int          last;
        logic [31:0] exp_addr;
        logic [31:0] new_rd;
        hs0      = n_hs;
        last     = 2 + a + d;
        exp_addr = addr & 32'h1FFF_FFFF;
        new_rd   = we ? exp_rd : rdata;
        for (int c = 0; c <= last; c++) begin
            if (c == 0) begin
                mread  = '{en: re, addr: we ? $urandom : addr, size: we ? rsize() : size};
                mwrite = '{en: we, addr: addr, size: size, data: data};
            end else begin
                garbage_req();
            end
            data_addr_ok = (c == 1 + a);
            data_data_ok = (c == 1 + a + d);
            if (c < 1 + a || c == last) data_data_ok = 1'($urandom_range(0, 1));
            data_rdata = (c == 1 + a + d) ? rdata : $urandom;
            @(negedge clk);
            chk("stall", stall, (c <= 1 + a + d) ? 1 : 0);
            chk("data_req", data_req, (c >= 1 && c <= 1 + a) ? 1 : 0);
            if (c == 0) chk("rd_hold", rd, exp_rd);
            if (c == 1) begin
                chk("data_addr", data_addr, exp_addr);
                chk("data_wr", data_wr, we);
                chk("data_size", data_size, size);
                if (we) chk("data_wdata", data_wdata, model_wdata(size, data));
            end
            if (c == a + 1 && a > 0) chk("addr_stable", data_addr, exp_addr);
            if (c == last) begin
                exp_rd = new_rd;
                chk("rd_done", rd, exp_rd);
                chk("one_handshake", n_hs - hs0, 1);
            end
            step();
        end
    endtask

    initial begin
        int hs0;
        resetn       = 1'b0;
        mread        = '0;
        mwrite       = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        exp_rd       = 32'd0;
        step();
        step();
        chk("rst_req", data_req, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_size", data_size, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_rd", rd, 0);
        chk("rst_stall", stall, 0);
        resetn = 1'b1;
        idle(2);

        do_txn(1, 0, 32'h8000_0010, MSIZE_W, 32'h0, 1, 3, 32'hDEAD_BEEF);
        do_txn(0, 1, 32'hA000_0003, MSIZE_B, 32'h0000_12AB, 0, 0, 32'h0);
        do_txn(1, 0, 32'h8000_0000, MSIZE_W, 32'h0, 0, 1, 32'h1111_2222);
        do_txn(1, 0, 32'h8000_0004, MSIZE_W, 32'h0, 2, 0, 32'h3333_4444);
        do_txn(1, 1, 32'h8000_0100, MSIZE_H, 32'h5566_7788, 1, 1, 32'hFFFF_0000);
        idle(1);

        hs0 = n_hs;
        mread  = '{en: 1'b1, addr: 32'h8000_0040, size: MSIZE_W};
        mwrite = '{en: 1'b0, addr: 32'h0, size: MSIZE_W, data: 32'h0};
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("data_phase_stall", stall, 1);
        resetn = 1'b0;
        step();
        resetn       = 1'b1;
        mread.en     = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        exp_rd       = 32'd0;
        @(negedge clk);
        chk("postrst_stall", stall, 0);
        chk("postrst_req", data_req, 0);
        chk("postrst_rd", rd, 0);
        step();
        idle(2);
        chk("postrst_handshakes", n_hs - hs0, 1);

        for (int t = 0; t < 200; t++) begin
            logic re;
            logic we;
            we = 1'($urandom_range(0, 1));
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            do_txn(re, we, $urandom, rsize(), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
